conv_frame_feeder: RTL
======================

# conv_frame_feeder

Stream source for the 5x5 convolution engine. It holds one 32x32 signed 8-bit image and up to MAX_FRAMES 25-tap kernels in local buffers. On a start command it replays the image once per requested frame, and drives the engine's pixel/weight load interface exactly as the engine expects. Each frame's first 25 pixel beats also carry that frame's kernel, with write-enable and tap address. It sits between the host/loader and the convolution top, replacing bench-driven stimulus in the integrated design.

## Interface
- MAX_FRAMES, 8: kernel slots in weight buffer (weight buffer depth = MAX_FRAMES*25)
- PIX_DEPTH, 1024: pixels per frame (32x32)
- KTAPS, 25: taps per kernel
- iCLK  in  1  clock
- iRST  in  1  synchronous, active-high reset
- iPixWr  in  1  host pixel buffer write strobe
- iPixAddr  in  10  pixel buffer address
- iPixData  in  8  signed pixel
- iWtWr  in  1  host weight buffer write strobe
- iWtAddr  in  8  weight buffer address (slot*25 + tap)
- iWtData  in  8  signed weight
- iStart  in  1  start pulse, sampled in IDLE only
- iFrames  in  4  frame count for this run
- oValid  out  1  pixel beat valid (to engine iValid)
- oX  out  8  signed pixel (to engine iX)
- oWren  out  1  weight write enable (to engine iWren)
- oADDR  out  5  kernel tap address (to engine iADDR)
- oW  out  8  signed weight (to engine iW)
- oBusy  out  1  high from start acceptance until oDone
- oDone  out  1  one-cycle pulse after the last beat of the run

## Operation
- States: IDLE, RUN, GAP (only with macro), DONE.
- IDLE with iStart=1: latch nfr = min(iFrames, MAX_FRAMES). Clear pix_cnt, frame_cnt, and wbase. Go to RUN. If nfr=0, go to DONE instead and emit no beats.
- RUN: each cycle issues pixel read address pix_cnt. If pix_cnt<25, it also issues weight read address wbase+pix_cnt.
- At pix_cnt=1023: pix_cnt wraps to 0, frame_cnt increments, and wbase += 25. The base is updated by adder, with no multiplier.
- After the last frame (frame_cnt=nfr-1, pix_cnt=1023), go to DONE. DONE lasts one cycle and asserts oDone, then the block returns to IDLE.
- Beats within a frame are back-to-back with no bubbles. Consecutive frames are back-to-back unless the macro is defined.
- Beat output for beat index p of frame f:
  - oX = pixel[p].
  - If p<25: oWren=1, oADDR=p, oW=weight[f*25+p].
  - Otherwise: oWren=0, oADDR=0, oW=0.
- Whenever oValid=0, oX, oW, oWren and oADDR are all 0.
- Host writes are accepted only when oBusy=0; writes while busy are dropped.
- iStart while busy is ignored.
- Buffer contents are not cleared by reset.

## Timing
- Reset values: all outputs 0; state IDLE.
- Buffers use synchronous read with 1-cycle latency. Control fields (valid, wren, addr, frame/tap) are delayed one register stage to align with read data, and all outputs are registered.
- Latency: iStart sampled at edge 0; oValid first high after edge 2; oBusy high after edge 1.
- Per run, oValid is high for exactly nfr*1024 cycles (plus gaps when the macro is defined).
- oDone pulses in the cycle after the final beat, and oBusy falls in that same cycle.
- iRST asserted mid-run: at the next edge, outputs go to 0, state goes to IDLE, and the pipeline stage is flushed. No partial oDone is issued.
- iFrames > MAX_FRAMES is clamped to MAX_FRAMES.

## Configuration
- FEEDER_GAP_EN defined:
  - Between consecutive frames, state GAP holds oValid=0 for GAP_CYCLES (localparam, 4) cycles so the engine's line buffers drain.
  - No gap is inserted after the last frame.
- FEEDER_GAP_EN undefined:
  - The GAP state and its counter are absent.
  - Frame f+1 beat 0 directly follows frame f beat 1023.

## Structure
- Package conv_pkg holds:
  - IMG_W=32, PIX_DEPTH=1024, KSIZE=5, KTAPS=25;
  - pixel and weight widths (8) and output width (16);
  - the feeder state enum.
- Sub-module conv_feeder_ram: simple dual-port synchronous RAM, parameterised by width and depth. It is instantiated twice, once for pixels and once for weights.

## Test plan
- Reset, then load pixels with value = addr[7:0] and weights with value = slot*25+tap. Start with iFrames=1. Expect 1024 beats, oX = 0,1,…,255,0,…; beats 0–24 have oWren=1, oADDR=0..24, oW=0..24; then a single oDone.
- Start with iFrames=3. Expect 3072 contiguous beats, and frame 2 beats 0–24 carry oW=50..74. Check that oBusy falls with oDone.
- Start with iFrames=0. Expect oDone pulse 2 cycles after start and zero oValid beats. Start with iFrames=12 and expect 8 frames (clamping).
- Assert iRST at beat 500 of frame 1. Next cycle all outputs are 0 and no oDone follows. A restart replays the buffer contents unchanged.
- Host write and iStart during a run are both dropped: buffer contents and beat count are unchanged.
- With FEEDER_GAP_EN and iFrames=2: exactly 4 oValid=0 cycles occur between beat 1023 and the next beat 0, and the total run is 2052 cycles from first beat to oDone.

Source files
------------

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared constants and types for the 5x5 convolution datapath and its
// frame feeder: image geometry, kernel geometry, data widths and the feeder
// state encoding.
// Optional build macro: FEEDER_GAP_EN. When it is defined, the enum gains
// the FS_GAP state that separates consecutive frames.
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int IMG_W     = 32;
  localparam int PIX_DEPTH = IMG_W * IMG_W;
  localparam int KSIZE     = 5;
  localparam int KTAPS     = KSIZE * KSIZE;

  localparam int PIX_W = 8;
  localparam int WT_W  = 8;
  localparam int OUT_W = 16;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
`ifdef FEEDER_GAP_EN
    FS_GAP  = 2'd2,
`endif
    FS_DONE = 2'd3
  } feederState_t;

  // Limit a requested frame count to the number of kernel slots available.
  function automatic logic [3:0] clampFrames(input logic [3:0] req,
                                             input logic [3:0] maxFr);
    return (req > maxFr) ? maxFr : req;
  endfunction

endpackage

// File: rtl/conv_feeder_ram.sv
// ---------------------------------------------------------------------------
// conv_feeder_ram
// Simple dual-port synchronous RAM: one write port, one read port, with
// one cycle of read latency. Contents are never cleared by any reset.
// Writes and reads outside DEPTH are ignored; an out-of-range read
// returns 0.
// Ports:
//   iCLK     clock
//   iWe      write enable
//   iWrAddr  write address
//   iWrData  write data
//   iRdAddr  read address (registered read)
//   oRdData  read data, valid one cycle after iRdAddr
// ---------------------------------------------------------------------------
module conv_feeder_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             iCLK,
  input  logic             iWe,
  input  logic [AW-1:0]    iWrAddr,
  input  logic [WIDTH-1:0] iWrData,
  input  logic [AW-1:0]    iRdAddr,
  output logic [WIDTH-1:0] oRdData
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             wrInRange_s;
  logic             rdInRange_s;

  assign wrInRange_s = ({1'b0, iWrAddr} < DEPTH_L);
  assign rdInRange_s = ({1'b0, iRdAddr} < DEPTH_L);

  // Write port.
  always_ff @(posedge iCLK) begin
    if (iWe && wrInRange_s) begin
      mem_r[iWrAddr] <= iWrData;
    end
  end

  // Registered read port.
  always_ff @(posedge iCLK) begin
    if (rdInRange_s) begin
      oRdData <= mem_r[iRdAddr];
    end else begin
      oRdData <= {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/conv_frame_feeder.sv
// ---------------------------------------------------------------------------
// conv_frame_feeder
// Stream source for the 5x5 convolution engine. It holds one 32x32 image
// and up to MAX_FRAMES 25-tap kernels. A start command replays the image
// once per frame. The first 25 beats of each frame also carry that frame's
// kernel taps.
// Optional build macro: FEEDER_GAP_EN. When it is defined, GAP_CYCLES idle
// beats are inserted between consecutive frames so the engine's line
// buffers can drain.
// Ports:
//   iCLK, iRST            clock, synchronous active-high reset
//   iPixWr/Addr/Data      host pixel buffer write (dropped while busy)
//   iWtWr/Addr/Data       host weight buffer write, addr = slot*25+tap
//   iStart, iFrames       run command (IDLE only), frame count
//   oValid, oX            pixel beat to engine
//   oWren, oADDR, oW      kernel tap write to engine
//   oBusy, oDone          run in progress / end-of-run pulse
// ---------------------------------------------------------------------------
module conv_frame_feeder
  import conv_pkg::*;
#(
  parameter int MAX_FRAMES = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iPixWr,
  input  logic [9:0]        iPixAddr,
  input  logic signed [7:0] iPixData,
  input  logic              iWtWr,
  input  logic [7:0]        iWtAddr,
  input  logic signed [7:0] iWtData,
  input  logic              iStart,
  input  logic [3:0]        iFrames,
  output logic              oValid,
  output logic signed [7:0] oX,
  output logic              oWren,
  output logic [4:0]        oADDR,
  output logic signed [7:0] oW,
  output logic              oBusy,
  output logic              oDone
);

  localparam int         WT_DEPTH = MAX_FRAMES * KTAPS;
  localparam logic [3:0] MAX_FR   = 4'(MAX_FRAMES);
  localparam logic [9:0] LAST_PIX = 10'(PIX_DEPTH - 1);
  localparam logic [9:0] KTAPS_P  = 10'(KTAPS);
  localparam logic [7:0] KTAPS_W  = 8'(KTAPS);
`ifdef FEEDER_GAP_EN
  localparam int         GAP_CYCLES = 4;
  localparam logic [2:0] GAP_LAST   = 3'(GAP_CYCLES - 1);
`endif

  feederState_t state_r, nextState_s;
  logic [9:0]   pixCnt_r, pixCntNext_s;
  logic [3:0]   frameCnt_r, frameCntNext_s;
  logic [7:0]   wbase_r, wbaseNext_s;
  logic [3:0]   nfr_r, nfrNext_s;
  logic [3:0]   clampNfr_s;
`ifdef FEEDER_GAP_EN
  logic [2:0]   gapCnt_r, gapCntNext_s;
`endif

  logic       issue_s;
  logic       doneState_s;
  logic       tapPhase_s;
  logic       hostWrOk_s;
  logic [7:0] wtRdAddr_s;
  logic [7:0] pixRd_s;
  logic [7:0] wtRd_s;

  // Stage aligned with the RAM read data.
  logic       valid1_r;
  logic       wren1_r;
  logic [4:0] addr1_r;
  logic       done1_r;

  // Host writes only land while the feeder is fully idle.
  assign hostWrOk_s = (state_r == FS_IDLE) && !oBusy;
  assign clampNfr_s = clampFrames(iFrames, MAX_FR);
  assign tapPhase_s = (pixCnt_r < KTAPS_P);

  conv_feeder_ram #(.WIDTH(PIX_W), .DEPTH(PIX_DEPTH), .AW(10)) uPixRam (
    .iCLK    (iCLK),
    .iWe     (iPixWr && hostWrOk_s),
    .iWrAddr (iPixAddr),
    .iWrData (iPixData),
    .iRdAddr (pixCnt_r),
    .oRdData (pixRd_s)
  );

  conv_feeder_ram #(.WIDTH(WT_W), .DEPTH(WT_DEPTH), .AW(8)) uWtRam (
    .iCLK    (iCLK),
    .iWe     (iWtWr && hostWrOk_s),
    .iWrAddr (iWtAddr),
    .iWrData (iWtData),
    .iRdAddr (wtRdAddr_s),
    .oRdData (wtRd_s)
  );

  // Weight read address: kernel base plus tap during the first 25 beats.
  always_comb begin
    wtRdAddr_s = 8'd0;
    if (issue_s && tapPhase_s) begin
      wtRdAddr_s = wbase_r + pixCnt_r[7:0];
    end else begin
      wtRdAddr_s = 8'd0;
    end
  end

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r <= FS_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state and counter-update logic.
  always_comb begin
    nextState_s    = state_r;
    pixCntNext_s   = pixCnt_r;
    frameCntNext_s = frameCnt_r;
    wbaseNext_s    = wbase_r;
    nfrNext_s      = nfr_r;
`ifdef FEEDER_GAP_EN
    gapCntNext_s   = gapCnt_r;
`endif
    issue_s        = 1'b0;
    doneState_s    = 1'b0;
    case (state_r)
      FS_IDLE: begin
        if (iStart && !oBusy) begin
          nfrNext_s      = clampNfr_s;
          pixCntNext_s   = 10'd0;
          frameCntNext_s = 4'd0;
          wbaseNext_s    = 8'd0;
          if (clampNfr_s == 4'd0) begin
            nextState_s = FS_DONE;
          end else begin
            nextState_s = FS_RUN;
          end
        end else begin
          nextState_s = FS_IDLE;
        end
      end
      FS_RUN: begin
        issue_s = 1'b1;
        if (pixCnt_r == LAST_PIX) begin
          pixCntNext_s = 10'd0;
          if (frameCnt_r == (nfr_r - 4'd1)) begin
            nextState_s = FS_DONE;
          end else begin
            frameCntNext_s = frameCnt_r + 4'd1;
            // The next kernel slot is reached by stepping the base, not by multiplying.
            wbaseNext_s    = wbase_r + KTAPS_W;
`ifdef FEEDER_GAP_EN
            gapCntNext_s   = 3'd0;
            nextState_s    = FS_GAP;
`else
            nextState_s    = FS_RUN;
`endif
          end
        end else begin
          pixCntNext_s = pixCnt_r + 10'd1;
        end
      end
`ifdef FEEDER_GAP_EN
      FS_GAP: begin
        if (gapCnt_r == GAP_LAST) begin
          nextState_s = FS_RUN;
        end else begin
          gapCntNext_s = gapCnt_r + 3'd1;
        end
      end
`endif
      FS_DONE: begin
        doneState_s = 1'b1;
        nextState_s = FS_IDLE;
      end
      default: begin
        nextState_s = FS_IDLE;
      end
    endcase
  end

  // Counters and run parameters.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pixCnt_r   <= 10'd0;
      frameCnt_r <= 4'd0;
      wbase_r    <= 8'd0;
      nfr_r      <= 4'd0;
`ifdef FEEDER_GAP_EN
      gapCnt_r   <= 3'd0;
`endif
    end else begin
      pixCnt_r   <= pixCntNext_s;
      frameCnt_r <= frameCntNext_s;
      wbase_r    <= wbaseNext_s;
      nfr_r      <= nfrNext_s;
`ifdef FEEDER_GAP_EN
      gapCnt_r   <= gapCntNext_s;
`endif
    end
  end

  // Control delayed one stage so it lines up with the RAM read data.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      valid1_r <= 1'b0;
      wren1_r  <= 1'b0;
      addr1_r  <= 5'd0;
      done1_r  <= 1'b0;
    end else begin
      valid1_r <= issue_s;
      wren1_r  <= issue_s && tapPhase_s;
      addr1_r  <= (issue_s && tapPhase_s) ? pixCnt_r[4:0] : 5'd0;
      done1_r  <= doneState_s;
    end
  end

  // Registered outputs; data is forced to zero on non-beat cycles.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oValid <= 1'b0;
      oX     <= 8'd0;
      oWren  <= 1'b0;
      oADDR  <= 5'd0;
      oW     <= 8'd0;
      oBusy  <= 1'b0;
      oDone  <= 1'b0;
    end else begin
      oValid <= valid1_r;
      oX     <= valid1_r ? pixRd_s : 8'd0;
      oWren  <= wren1_r;
      oADDR  <= addr1_r;
      oW     <= wren1_r ? wtRd_s : 8'd0;
      // Sampling the state one cycle late makes busy fall together with oDone.
      oBusy  <= (state_r != FS_IDLE);
      oDone  <= done1_r;
    end
  end

endmodule
